// File: rtl/axi4_lite_req_arbiter.sv
// rtl/axi4_lite_req_arbiter.sv - round-robin arbiter sharing one AXI4-Lite master port
// Optional macro AXI_ARB_TIMEOUT_EN aborts stalled AXI wait states with DECERR.
module axi4_lite_req_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [31:0]           AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [31:0]           WDATA,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [31:0]           ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [31:0]           RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_gnt;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_awvalid;
    logic               r_wvalid;
    logic               r_bready;
    logic               r_arvalid;
    logic               r_rready;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [31:0]        r_rdata;
    logic [1:0]         r_resp;

    logic               w_any;
    logic [IDX_W-1:0]   w_pick;
    int                 w_idx;
    logic [NUM_REQ-1:0] w_pick_oh;
    logic [NUM_REQ-1:0] w_gnt_oh;
    logic               w_progress;

    // Scan downward so the nearest requester after r_last is the one left standing.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = int'(r_last) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (req_valid[w_idx[IDX_W-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        case (r_state)
            S_WR_ADDR: w_progress = (!r_awvalid || AWREADY) && (!r_wvalid || WREADY);
            S_WR_RESP: w_progress = BVALID;
            S_RD_ADDR: w_progress = ARREADY;
            S_RD_DATA: w_progress = RVALID;
            default:   w_progress = 1'b0;
        endcase
    end

    assign w_pick_oh = NUM_REQ'(1) << w_pick;
    assign w_gnt_oh  = NUM_REQ'(1) << r_gnt;
    assign req_ready = (r_state == S_IDLE && w_any && !reset) ? w_pick_oh : '0;

`ifdef AXI_ARB_TIMEOUT_EN
    logic [15:0] r_tmo;
    logic        w_wait;
    assign w_wait = (r_state == S_WR_ADDR) || (r_state == S_WR_RESP) ||
                    (r_state == S_RD_ADDR) || (r_state == S_RD_DATA);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_last      <= IDX_W'(NUM_REQ - 1);
            r_gnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= '0;
            r_rdata     <= '0;
            r_resp      <= '0;
`ifdef AXI_ARB_TIMEOUT_EN
            r_tmo       <= '0;
`endif
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_pick;
                        r_last  <= w_pick;
                        r_addr  <= req_addr[32*w_pick +: 32];
                        r_wdata <= req_wdata[32*w_pick +: 32];
                        if (req_write[w_pick]) begin
                            r_state   <= S_WR_ADDR;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end else begin
                            r_state   <= S_RD_ADDR;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                S_WR_ADDR: begin
                    if (AWREADY) r_awvalid <= 1'b0;
                    if (WREADY)  r_wvalid  <= 1'b0;
                    if (w_progress) begin
                        r_state  <= S_WR_RESP;
                        r_bready <= 1'b1;
                    end
                end
                S_WR_RESP: begin
                    if (BVALID) begin
                        r_bready    <= 1'b0;
                        r_resp      <= BRESP;
                        r_rdata     <= '0;
                        r_rsp_valid <= w_gnt_oh;
                        r_state     <= S_DONE;
                    end
                end
                S_RD_ADDR: begin
                    if (ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (RVALID) begin
                        r_rready    <= 1'b0;
                        r_rdata     <= RDATA;
                        r_resp      <= RRESP;
                        r_rsp_valid <= w_gnt_oh;
                        r_state     <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef AXI_ARB_TIMEOUT_EN
            // A handshake on the expiry cycle wins; only a true stall aborts.
            if (w_wait && !w_progress) r_tmo <= r_tmo + 16'd1;
            else                       r_tmo <= '0;
            if (w_wait && !w_progress && r_tmo == 16'(TIMEOUT_CYCLES - 1)) begin
                r_awvalid   <= 1'b0;
                r_wvalid    <= 1'b0;
                r_bready    <= 1'b0;
                r_arvalid   <= 1'b0;
                r_rready    <= 1'b0;
                r_resp      <= 2'b11;
                r_rdata     <= '0;
                r_rsp_valid <= w_gnt_oh;
                r_state     <= S_DONE;
            end
`endif
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_resp  = r_resp;
    assign AWADDR    = r_addr;
    assign AWVALID   = r_awvalid;
    assign WDATA     = r_wdata;
    assign WVALID    = r_wvalid;
    assign BREADY    = r_bready;
    assign ARADDR    = r_addr;
    assign ARVALID   = r_arvalid;
    assign RREADY    = r_rready;

endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// tb/tb_axi4_lite_req_arbiter.sv - scoreboard bench for axi4_lite_req_arbiter
module tb_axi4_lite_req_arbiter;
    localparam int NUM_REQ = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [NUM_REQ*32-1:0] req_addr, req_wdata;
    logic [31:0]           rsp_rdata;
    logic [1:0]            rsp_resp;
    logic [31:0]           AWADDR, WDATA, ARADDR, RDATA;
    logic                  AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic                  ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]            BRESP, RRESP;

    logic        tb_valid [NUM_REQ];
    logic        tb_write [NUM_REQ];
    logic [31:0] tb_addr  [NUM_REQ];
    logic [31:0] tb_wdata [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign req_valid[i]            = tb_valid[i];
        assign req_write[i]            = tb_write[i];
        assign req_addr[32*i +: 32]    = tb_addr[i];
        assign req_wdata[32*i +: 32]   = tb_wdata[i];
    end

    axi4_lite_req_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   exp_g[$];
    rsp_t exp_r[$];

    // slave configuration and state
    int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic        cfg_r_hold = 1'b0;
    logic [31:0] mem [logic [31:0]];
    int          aw_cnt, w_cnt, ar_cnt;
    logic        p_aw, p_w, p_ar, p_b, p_r, aw_got, w_got;
    logic [31:0] s_awaddr, s_wdata, s_araddr;

    // protocol activity counters
    int   aw_cyc, w_cyc, both_cyc, ar_cyc, b_phases;
    logic prev_bready;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{req_ready, rsp_valid, rsp_rdata, rsp_resp, AWADDR, AWVALID, WDATA,
                 WVALID, BREADY, ARADDR, ARVALID, RREADY};
    endfunction

    task automatic clr_counts();
        aw_cyc = 0; w_cyc = 0; both_cyc = 0; ar_cyc = 0; b_phases = 0;
    endtask

    task automatic push_rsp(int idx, logic [31:0] rdata, logic [1:0] resp);
        rsp_t r;
        r.idx = idx; r.rdata = rdata; r.resp = resp;
        exp_r.push_back(r);
    endtask

    // Called at posedge+2; holds the request until granted, then releases it.
    task automatic drive(int idx, logic wr, logic [31:0] addr, logic [31:0] data);
        bit got = 0;
        tb_valid[idx] = 1'b1;
        tb_write[idx] = wr;
        tb_addr[idx]  = addr;
        tb_wdata[idx] = data;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (req_ready[idx]) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL grant_timeout: requester %0d got no req_ready expected one", idx);
        end
        @(posedge clk); #2;
        tb_valid[idx] = 1'b0;
    endtask

    task automatic wait_quiet();
        bit done = 0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (exp_g.size() == 0 && exp_r.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL quiet_timeout: got %0d grants %0d rsps pending expected 0",
                     exp_g.size(), exp_r.size());
            exp_g.delete();
            exp_r.delete();
        end
        @(posedge clk); #2;
    endtask

    // grant monitor
    int                 mon_g;
    logic [NUM_REQ-1:0] mon_goh;
    initial forever begin
        @(negedge clk);
        if (!reset && req_ready !== '0) begin
            n_cmp++;
            if (exp_g.size() == 0) begin
                n_fail++;
                $display("FAIL grant_unexpected: got %b expected none", req_ready);
            end else begin
                mon_g   = exp_g.pop_front();
                mon_goh = NUM_REQ'(1) << mon_g;
                if (req_ready !== mon_goh) begin
                    n_fail++;
                    $display("FAIL grant_order: got %b expected %b", req_ready, mon_goh);
                end
            end
        end
    end

    // response monitor
    rsp_t               mon_r;
    logic [NUM_REQ-1:0] mon_roh;
    initial forever begin
        @(negedge clk);
        if (!reset && rsp_valid !== '0) begin
            n_cmp++;
            if (exp_r.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got %b expected none", rsp_valid);
            end else begin
                mon_r   = exp_r.pop_front();
                mon_roh = NUM_REQ'(1) << mon_r.idx;
                if (rsp_valid !== mon_roh || rsp_rdata !== mon_r.rdata || rsp_resp !== mon_r.resp) begin
                    n_fail++;
                    $display("FAIL rsp: got valid=%b rdata=%h resp=%b expected valid=%b rdata=%h resp=%b",
                             rsp_valid, rsp_rdata, rsp_resp, mon_roh, mon_r.rdata, mon_r.resp);
                end
            end
        end
    end

    initial begin
        prev_bready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (AWVALID) aw_cyc++;
                if (WVALID) w_cyc++;
                if (AWVALID && WVALID) both_cyc++;
                if (ARVALID) ar_cyc++;
                if (BREADY && !prev_bready) b_phases++;
            end
            prev_bready = BREADY;
        end
    end

    // AXI4-Lite slave: ready after a configurable wait, memory-backed data
    initial begin
        AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
        BRESP = 0; RRESP = 0; RDATA = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_got = 0; w_got = 0;
        p_aw = 0; p_w = 0; p_ar = 0; p_b = 0; p_r = 0;
        s_awaddr = 0; s_wdata = 0; s_araddr = 0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_got = 0; w_got = 0;
            end else begin
                if (p_b) BVALID = 0;
                if (p_r) RVALID = 0;
                if (p_aw) aw_got = 1;
                if (p_w) w_got = 1;
                if (aw_got && w_got) begin
                    mem[s_awaddr] = s_wdata;
                    BVALID = 1; BRESP = cfg_bresp;
                    aw_got = 0; w_got = 0;
                end
                if (p_ar && !cfg_r_hold) begin
                    RVALID = 1; RRESP = cfg_rresp;
                    RDATA = mem.exists(s_araddr) ? mem[s_araddr] : 32'h0;
                end
                AWREADY = AWVALID && (aw_cnt >= cfg_aw_dly);
                aw_cnt  = AWVALID ? aw_cnt + 1 : 0;
                WREADY  = WVALID && (w_cnt >= cfg_w_dly);
                w_cnt   = WVALID ? w_cnt + 1 : 0;
                ARREADY = ARVALID && (cfg_ar_dly >= 0) && (ar_cnt >= cfg_ar_dly);
                ar_cnt  = ARVALID ? ar_cnt + 1 : 0;
                if (AWVALID && AWREADY) s_awaddr = AWADDR;
                if (WVALID && WREADY) s_wdata = WDATA;
                if (ARVALID && ARREADY) s_araddr = ARADDR;
            end
            p_aw = AWVALID && AWREADY;
            p_w  = WVALID && WREADY;
            p_ar = ARVALID && ARREADY;
            p_b  = BVALID && BREADY;
            p_r  = RVALID && RREADY;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            tb_valid[i] = 0; tb_write[i] = 0; tb_addr[i] = 0; tb_wdata[i] = 0;
        end
        clr_counts();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'(any_out()), 64'd0);
        #1;
        reset = 1'b0;

        // zero-wait write from requester 0
        clr_counts();
        exp_g.push_back(0);
        push_rsp(0, 32'h0, 2'b00);
        drive(0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF);
        wait_quiet();
        check("wr_aw_cycles", 64'(aw_cyc), 64'd1);
        check("wr_w_cycles", 64'(w_cyc), 64'd1);
        check("wr_aw_w_same_cycle", 64'(both_cyc), 64'd1);
        check("wr_bready_phases", 64'(b_phases), 64'd1);

        // read back from requester 1
        clr_counts();
        exp_g.push_back(1);
        push_rsp(1, 32'hDEAD_BEEF, 2'b00);
        drive(1, 1'b0, 32'h8000_0004, 32'h0);
        wait_quiet();
        check("rd_ar_cycles", 64'(ar_cyc), 64'd1);

        // contention: both held for four transactions
        exp_g.push_back(0); exp_g.push_back(1); exp_g.push_back(0); exp_g.push_back(1);
        push_rsp(0, 32'h0, 2'b00);
        push_rsp(1, 32'hDEAD_BEEF, 2'b00);
        push_rsp(0, 32'h0, 2'b00);
        push_rsp(1, 32'h1111_1111, 2'b00);
        fork
            begin
                drive(0, 1'b1, 32'h10, 32'h1111_1111);
                drive(0, 1'b1, 32'h14, 32'h2222_2222);
            end
            begin
                drive(1, 1'b0, 32'h8000_0004, 32'h0);
                drive(1, 1'b0, 32'h10, 32'h0);
            end
        join
        wait_quiet();

        // split write handshake with SLVERR
        clr_counts();
        cfg_aw_dly = 3; cfg_bresp = 2'b10;
        exp_g.push_back(1);
        push_rsp(1, 32'h0, 2'b10);
        drive(1, 1'b1, 32'h20, 32'h3333_3333);
        wait_quiet();
        check("split_aw_cycles", 64'(aw_cyc), 64'd4);
        check("split_w_cycles", 64'(w_cyc), 64'd1);
        check("split_overlap", 64'(both_cyc), 64'd1);
        check("split_bready_phases", 64'(b_phases), 64'd1);
        cfg_aw_dly = 0; cfg_bresp = 2'b00;

        // read SLVERR passthrough
        cfg_rresp = 2'b10;
        exp_g.push_back(1);
        push_rsp(1, 32'h2222_2222, 2'b10);
        drive(1, 1'b0, 32'h14, 32'h0);
        wait_quiet();
        cfg_rresp = 2'b00;

        // reset while in RD_DATA, then pointer must favour requester 0 again
        begin
            bit in_rd = 0;
            cfg_r_hold = 1'b1;
            exp_g.push_back(0);
            drive(0, 1'b0, 32'h8000_0004, 32'h0);
            for (int n = 0; n < 50; n++) begin
                @(negedge clk);
                if (RREADY) begin
                    in_rd = 1;
                    break;
                end
            end
            check("reached_rd_data", 64'(in_rd), 64'd1);
            @(posedge clk); #2;
            reset = 1'b1;
            @(posedge clk); #1;
            check("midtx_reset_outputs", 64'(any_out()), 64'd0);
            #1;
            reset = 1'b0;
            cfg_r_hold = 1'b0;
        end
        exp_g.push_back(0); exp_g.push_back(1);
        push_rsp(0, 32'h2222_2222, 2'b00);
        push_rsp(1, 32'h1111_1111, 2'b00);
        fork
            drive(0, 1'b0, 32'h14, 32'h0);
            drive(1, 1'b0, 32'h10, 32'h0);
        join
        wait_quiet();

`ifdef AXI_ARB_TIMEOUT_EN
        clr_counts();
        cfg_ar_dly = -1;
        exp_g.push_back(0);
        push_rsp(0, 32'h0, 2'b11);
        drive(0, 1'b0, 32'h50, 32'h0);
        wait_quiet();
        check("tmo_ar_cycles", 64'(ar_cyc), 64'd8);
        cfg_ar_dly = 0;
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_lite_req_arbiter.md
Name: axi4_lite_req_arbiter

Overview:
- Shares one AXI4-Lite master port between NUM_REQ local requesters. The downstream target is the team's AXI4-Lite register slave.
- Each requester presents a single-beat read or write on a simple valid/ready request port. The block arbitrates round-robin, runs the full AXI4-Lite handshake, and returns data/response to the winner.
- Exactly one transaction is outstanding at a time, so there is no reordering.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- TIMEOUT_CYCLES, 256, cycles waited in any AXI wait state before abort; used only with AXI_ARB_TIMEOUT_EN

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request pending
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*32  packed byte addresses; requester i uses bits [32*i+31:32*i]
- req_wdata  in  NUM_REQ*32  packed write data, same packing as req_addr
- req_ready  out  NUM_REQ  one-hot accept pulse
- rsp_valid  out  NUM_REQ  one-hot completion pulse
- rsp_rdata  out  32  read data, valid with rsp_valid
- rsp_resp  out  2  AXI response code, valid with rsp_valid
- AWADDR  out  32, AWVALID  out  1, AWREADY  in  1  write address channel
- WDATA  out  32, WVALID  out  1, WREADY  in  1  write data channel
- BRESP  in  2, BVALID  in  1, BREADY  out  1  write response channel
- ARADDR  out  32, ARVALID  out  1, ARREADY  in  1  read address channel
- RDATA  in  32, RRESP  in  2, RVALID  in  1, RREADY  out  1  read data channel

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has top priority after reset.
- FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - If any req_valid is set, pick the first set bit scanning from last+1 upward with wrap.
  - Pulse req_ready[g] for exactly this cycle.
  - Latch g, addr, wdata and write into internal registers; set last = g.
  - Next state is WR_ADDR if write, else RD_ADDR.
- Requester side:
  - A requester must hold req_valid and its fields until req_ready. Fields are not sampled afterwards.
  - A requester may drop req_valid before being granted; that is not an error.
- WR_ADDR:
  - AWVALID and WVALID asserted together, AWADDR/WDATA from latches.
  - Each valid drops on its own handshake cycle (VALID & READY). Handshakes may complete in either order or in the same cycle.
  - Once both are done, go to WR_RESP.
- WR_RESP:
  - BREADY = 1.
  - On BVALID, capture BRESP into rsp_resp, set rsp_rdata = 0, go to DONE.
- RD_ADDR: ARVALID = 1; on ARREADY go to RD_DATA.
- RD_DATA:
  - RREADY = 1.
  - On RVALID, capture RDATA/RRESP, go to DONE.
- DONE:
  - Pulse rsp_valid[g] one cycle, then return to IDLE.
  - rsp_rdata/rsp_resp hold their values until the next DONE.
- Handshake and issue rules:
  - VALID signals never drop before their handshake; the AXI address/data outputs stay stable while VALID is asserted.
  - No new grant is issued in the cycle leaving DONE, so a full transaction is at least 4 cycles.
  - Minimum latency from req_ready to rsp_valid is 3 cycles with zero-wait slave.
- Fairness: a requester holding req_valid continuously is granted within NUM_REQ transactions.
- Reset mid-transaction: all VALID/READY outputs drop the next cycle, FSM goes to IDLE, and no rsp_valid is issued.
- No address decode here: the slave reports SLVERR (2'b10), which is passed through unchanged.

Optional Feature:
- Macro: AXI_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entering WR_ADDR, WR_RESP, RD_ADDR or RD_DATA and increments each cycle spent there.
  - On reaching TIMEOUT_CYCLES, all AXI VALID/READY outputs drop, rsp_resp = 2'b11 (DECERR), rsp_rdata = 0, and the FSM goes to DONE.
- When undefined: no counter; the FSM waits indefinitely.

Test Plan:
- Write: req 0 write addr 0x80000004 data 0xDEADBEEF, slave ready immediately -> AW/W in the same cycle, BREADY, rsp_valid=01, rsp_resp=00.
- Read: req 1 read 0x80000004 returning 0xDEADBEEF -> rsp_valid=10, rsp_rdata=0xDEADBEEF, rsp_resp=00.
- Contention: NUM_REQ=2, both req_valid held for 4 transactions after reset -> grant order 0,1,0,1.
- Split write handshake: WREADY 3 cycles before AWREADY -> WVALID drops after its handshake, AWVALID held; exactly one BREADY phase; slave returns BRESP=10 -> rsp_resp=10.
- Reset: assert reset while in RD_DATA -> next cycle all outputs 0, no rsp_valid; the next request is granted to requester 0.
- Timeout (AXI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): ARREADY never asserted -> ARVALID drops after 8 cycles, rsp_resp=11.
